// File: rtl/rx_cgs_sync_pkg.sv
// Shared JESD204B receive-side definitions: control characters and CS state codes.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package rx_cgs_sync_pkg;

  // Control characters as seen after the 8b/10b decoder (with K flag set)
  localparam logic [7:0] K28_5 = 8'hBC;  // comma, used for code-group sync
  localparam logic [7:0] K28_0 = 8'h1C;  // /R/, starts ILAS
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/, multiframe alignment

  // Code-group sync state encodings (also used by the transmitter control)
  typedef logic [1:0] cs_state_t;
  localparam cs_state_t CS_INIT  = 2'b00;
  localparam cs_state_t CS_CHECK = 2'b01;
  localparam cs_state_t CS_DATA  = 2'b10;

  // True when the decoded character is the K28.5 comma
  function automatic logic is_k28_5(input logic k, input logic [7:0] data);
    return k && (data == K28_5);
  endfunction

endpackage

// File: rtl/rx_cgs_sync_if.sv
// Decoded character stream from the 8b/10b decoder into the CGS block.
// Latency: n/a (wires only).
// Backpressure: none; vld=0 marks an idle cycle, the consumer never stalls the source.
interface rx_cgs_sync_if;
  logic       vld;
  logic [7:0] data;
  logic       k;
  logic       disp_err;
  logic       nit_err;

  modport master (output vld, data, k, disp_err, nit_err);
  modport slave  (input  vld, data, k, disp_err, nit_err);
endinterface

// File: rtl/rx_err_monitor.sv
// Code-error leaky counter and single-error SYNC~ report pulse timer for CS_DATA.
// Latency: err_cnt/report_active registered (1 cycle); threshold_hit is combinational.
// Backpressure: none; vld=0 holds the counters, frame ticks still time the report pulse.
module rx_err_monitor #(
  parameter int ERR_THRESH       = 3,
  parameter int ERR_PULSE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       vld,
  input  logic       code_err,
  input  logic       frame_tick,
  input  logic       rpt_en,
  output logic [1:0] err_cnt,
  output logic       threshold_hit,
  output logic       report_active
);

  localparam logic [2:0] THRESH     = 3'(ERR_THRESH);
  localparam logic [1:0] FCNT_LAST  = 2'(ERR_PULSE_FRAMES - 1);

  logic [1:0] good_run;
  logic [1:0] fcnt;
  logic [2:0] err_next;

  assign err_next      = {1'b0, err_cnt} + 3'd1;
  assign threshold_hit = en & code_err & (err_next >= THRESH);

  // Error counting with decay every 4 clean characters, plus report pulse timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt       <= '0;
      good_run      <= '0;
      fcnt          <= '0;
      report_active <= 1'b0;
    end else if (clr || threshold_hit) begin
      err_cnt       <= '0;
      good_run      <= '0;
      fcnt          <= '0;
      report_active <= 1'b0;
    end else if (en) begin
      if (vld) begin
        if (code_err) begin
          err_cnt  <= err_cnt + 2'd1;
          good_run <= '0;
        end else if (good_run == 2'd3) begin
          good_run <= '0;
          if (err_cnt != 2'd0) begin
            err_cnt <= err_cnt - 2'd1;
          end
        end else begin
          good_run <= good_run + 2'd1;
        end
      end
      // A running pulse is never restarted or stretched by further errors;
      // the tick coinciding with the starting error is deliberately not counted.
      if (report_active) begin
        if (frame_tick) begin
          if (fcnt == FCNT_LAST) begin
            report_active <= 1'b0;
            fcnt          <= '0;
          end else begin
            fcnt <= fcnt + 2'd1;
          end
        end
      end else if (code_err && rpt_en) begin
        report_active <= 1'b1;
        fcnt          <= '0;
      end
    end
  end

endmodule

// File: rtl/rx_cgs_sync.sv
// JESD204B receiver code-group sync: comma search, LMFC-aligned SYNC~ release, error reporting.
// Latency: all outputs change 1 clk after the causing input cycle.
// Backpressure: none; rx.vld=0 cycles hold counters and state.
module rx_cgs_sync
  import rx_cgs_sync_pkg::*;
#(
  parameter int CGS_K_COUNT      = 4,
  parameter int ERR_THRESH       = 3,
  parameter int ERR_PULSE_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  rx_cgs_sync_if.slave  rx,
  input  logic          i_frame_tick,
  input  logic          i_lmfc_tick,
  input  logic          i_err_rpt_en,
  input  logic          i_resync,
  output logic          o_sync_n,
  output logic [1:0]    o_cs_state,
  output logic          o_cgs_done,
  output logic [1:0]    o_err_cnt
);

  localparam logic [2:0] KCNT_LAST = 3'(CGS_K_COUNT - 1);

  cs_state_t  state;
  logic [2:0] kcnt;
  logic       sync_rel;       // SYNC~ released in CS_CHECK after an LMFC boundary
  logic       code_err;
  logic       comma;
  logic       other_char;     // any valid non-comma, including errored ones
  logic       mon_en;
  logic       mon_clr;
  logic       threshold_hit;
  logic       report_active;

  assign code_err   = rx.vld & (rx.disp_err | rx.nit_err);
  assign comma      = rx.vld & is_k28_5(rx.k, rx.data) & ~code_err;
  assign other_char = rx.vld & ~comma;

  assign mon_en  = (state == CS_DATA);
  assign mon_clr = i_resync | (state != CS_DATA);

  rx_err_monitor #(
    .ERR_THRESH       (ERR_THRESH),
    .ERR_PULSE_FRAMES (ERR_PULSE_FRAMES)
  ) u_err_mon (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (mon_en),
    .clr           (mon_clr),
    .vld           (rx.vld),
    .code_err      (code_err),
    .frame_tick    (i_frame_tick),
    .rpt_en        (i_err_rpt_en),
    .err_cnt       (o_err_cnt),
    .threshold_hit (threshold_hit),
    .report_active (report_active)
  );

  // CS state machine, consecutive comma counter and CS_CHECK release flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CS_INIT;
      kcnt     <= '0;
      sync_rel <= 1'b0;
    end else if (i_resync) begin
      state    <= CS_INIT;
      kcnt     <= '0;
      sync_rel <= 1'b0;
    end else begin
      case (state)
        CS_INIT: begin
          sync_rel <= 1'b0;
          if (comma) begin
            if (kcnt == KCNT_LAST) begin
              state <= CS_CHECK;
              kcnt  <= '0;
            end else begin
              kcnt <= kcnt + 3'd1;
            end
          end else if (rx.vld) begin
            kcnt <= '0;
          end
        end
        CS_CHECK: begin
          // A code error wins over an LMFC tick in the same cycle
          if (code_err) begin
            state    <= CS_INIT;
            sync_rel <= 1'b0;
          end else if (!sync_rel) begin
            if (other_char) begin
              state <= CS_INIT;
            end else if (i_lmfc_tick) begin
              sync_rel <= 1'b1;
            end
          end else if (other_char) begin
            state <= CS_DATA;
          end
        end
        CS_DATA: begin
          if (threshold_hit) begin
            state    <= CS_INIT;
            sync_rel <= 1'b0;
          end
        end
        default: begin
          state    <= CS_INIT;
          kcnt     <= '0;
          sync_rel <= 1'b0;
        end
      endcase
    end
  end

  // SYNC~ is the release flag before data, and the inverted report pulse during data
  assign o_sync_n   = (state == CS_DATA) ? ~report_active : sync_rel;
  assign o_cs_state = state;
  assign o_cgs_done = (state == CS_DATA);

endmodule

// File: tb/tb_rx_cgs_sync.sv
// Self-checking bench for rx_cgs_sync: directed scenarios plus random stimulus vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_cgs_sync;
  import rx_cgs_sync_pkg::*;

  localparam int KC  = 4;
  localparam int TH  = 3;
  localparam int EPF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       lmfc_tick = 1'b0;
  logic       err_rpt_en = 1'b1;
  logic       resync = 1'b0;
  logic       sync_n;
  logic [1:0] cs_state;
  logic       cgs_done;
  logic [1:0] err_cnt;

  rx_cgs_sync_if rx_if();

  rx_cgs_sync #(
    .CGS_K_COUNT      (KC),
    .ERR_THRESH       (TH),
    .ERR_PULSE_FRAMES (EPF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx_if.slave),
    .i_frame_tick (frame_tick),
    .i_lmfc_tick  (lmfc_tick),
    .i_err_rpt_en (err_rpt_en),
    .i_resync     (resync),
    .o_sync_n     (sync_n),
    .o_cs_state   (cs_state),
    .o_cgs_done   (cgs_done),
    .o_err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: link phase 0=init 1=check 2=data, plus plain integer counters
  int m_state;
  int m_kcnt;
  int m_err;
  int m_good;
  int m_rpt_left;     // frame ticks still to wait before the report pulse ends
  bit m_released;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_kcnt = 0; m_err = 0; m_good = 0; m_rpt_left = 0; m_released = 0;
  endtask

  task automatic model_step();
    logic ce;
    logic cm;
    ce = rx_if.vld & (rx_if.disp_err | rx_if.nit_err);
    cm = rx_if.vld & rx_if.k & (rx_if.data == K28_5) & ~ce;
    if (resync) begin
      model_reset();
    end else begin
      case (m_state)
        0: begin
          if (cm) begin
            m_kcnt++;
            if (m_kcnt == KC) begin m_state = 1; m_kcnt = 0; end
          end else if (rx_if.vld) begin
            m_kcnt = 0;
          end
        end
        1: begin
          if (ce) begin
            m_state = 0; m_released = 0;
          end else if (rx_if.vld && !cm) begin
            m_state = m_released ? 2 : 0;
          end else if (lmfc_tick) begin
            m_released = 1;
          end
        end
        default: begin
          if (ce && (m_err + 1 >= TH)) begin
            model_reset();
          end else begin
            if (rx_if.vld) begin
              if (ce) begin
                m_err++; m_good = 0;
              end else begin
                m_good++;
                if (m_good == 4) begin
                  m_good = 0;
                  if (m_err > 0) m_err--;
                end
              end
            end
            if (m_rpt_left > 0) begin
              if (frame_tick) m_rpt_left--;
            end else if (ce && err_rpt_en) begin
              m_rpt_left = EPF;
            end
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    int exp_sync;
    exp_sync = (m_state == 0) ? 0 : (m_state == 1) ? int'(m_released) : int'(m_rpt_left == 0);
    check("state",   32'(cs_state), 32'(m_state));
    check("sync_n",  32'(sync_n),   32'(exp_sync));
    check("done",    32'(cgs_done), 32'(m_state == 2));
    check("err_cnt", 32'(err_cnt),  32'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic send(input logic k, input logic [7:0] d, input logic de, input logic ne,
                      input logic lmfc, input logic frame);
    rx_if.vld = 1'b1; rx_if.k = k; rx_if.data = d;
    rx_if.disp_err = de; rx_if.nit_err = ne;
    lmfc_tick = lmfc; frame_tick = frame;
    cycle();
    lmfc_tick = 1'b0; frame_tick = 1'b0;
    rx_if.disp_err = 1'b0; rx_if.nit_err = 1'b0;
  endtask

  task automatic comma(input logic lmfc);
    send(1'b1, K28_5, 1'b0, 1'b0, lmfc, 1'b0);
  endtask

  task automatic bring_up();
    repeat (KC) comma(1'b0);
    comma(1'b1);
    send(1'b1, K28_0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  32'(cs_state), 32'(0));
    check({tag, "_sync_n"}, 32'(sync_n),   32'(0));
    check({tag, "_done"},   32'(cgs_done), 32'(0));
    check({tag, "_errcnt"}, 32'(err_cnt),  32'(0));
  endtask

  initial begin
    logic [7:0] dv;
    int sel;
    int thr;
    rx_if.vld = 1'b0; rx_if.k = 1'b0; rx_if.data = 8'h00;
    rx_if.disp_err = 1'b0; rx_if.nit_err = 1'b0;
    model_reset();

    // Reset state
    #3;
    check_reset_values("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Broken comma run stays in init; a fourth clean comma afterwards advances
    repeat (3) comma(1'b0);
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) comma(1'b0);
    check("broken_state", 32'(cs_state), 32'(0));
    check("broken_sync",  32'(sync_n),   32'(0));
    comma(1'b0);
    check("broken_4th", 32'(cs_state), 32'(1));
    // Non-comma while SYNC~ still low drops back to init
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    check("chk_noncomma", 32'(cs_state), 32'(0));

    // Full CGS: six commas, LMFC 10 cycles later, then /R/
    repeat (4) comma(1'b0);
    check("cgs_check", 32'(cs_state), 32'(1));
    repeat (2) comma(1'b0);
    repeat (9) comma(1'b0);
    check("cgs_pre_lmfc", 32'(sync_n), 32'(0));
    comma(1'b1);
    check("cgs_release", 32'(sync_n), 32'(1));
    send(1'b1, K28_0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("cgs_data",  32'(cs_state), 32'(2));
    check("cgs_done",  32'(cgs_done), 32'(1));

    // Single error report; frame tick in the error cycle is ignored
    send(1'b0, 8'h3A, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rpt_errcnt", 32'(err_cnt), 32'(1));
    check("rpt_fall",   32'(sync_n),  32'(0));
    for (int i = 1; i <= 8; i++) begin
      send(1'b0, 8'(i), 1'b0, 1'b0, 1'b0, (i == 3) || (i == 7));
      if (i == 4) check("rpt_decay", 32'(err_cnt), 32'(0));
      if (i == 6) check("rpt_still_low", 32'(sync_n), 32'(0));
      if (i == 7) check("rpt_rise", 32'(sync_n), 32'(1));
    end

    // Threshold: three not-in-table errors close together
    send(1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'h13, 1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b0, 8'h14, 1'b0, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h15, 1'b0, 1'b1, 1'b0, 1'b0);
    check("thr_state",  32'(cs_state), 32'(0));
    check("thr_errcnt", 32'(err_cnt),  32'(0));
    for (int i = 0; i < 12; i++) send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, i[0]);
    check("thr_hold", 32'(sync_n), 32'(0));

    // Code error in CS_CHECK together with LMFC tick
    repeat (KC) comma(1'b0);
    send(1'b1, K28_5, 1'b1, 1'b0, 1'b1, 1'b0);
    check("chk_err_state", 32'(cs_state), 32'(0));
    check("chk_err_sync",  32'(sync_n),   32'(0));

    // Resync pulse in data
    bring_up();
    resync = 1'b1;
    send(1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    resync = 1'b0;
    check("resync_state", 32'(cs_state), 32'(0));
    check("resync_sync",  32'(sync_n),   32'(0));

    // Asynchronous reset in the middle of a report
    bring_up();
    send(1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomised traffic against the model
    for (int n = 0; n < 5000; n++) begin
      rx_if.vld = ($urandom_range(99) < 85);
      sel = $urandom_range(99);
      thr = (m_state == 2) ? 20 : 95;
      dv = 8'($urandom);
      if (sel < thr) begin
        rx_if.k = 1'b1; rx_if.data = K28_5;
      end else if (sel < thr + 2) begin
        rx_if.k = 1'b1; rx_if.data = K28_0;
      end else if (sel < thr + 4) begin
        rx_if.k = 1'b1; rx_if.data = K28_3;
      end else begin
        rx_if.k = dv[7]; rx_if.data = dv;
      end
      rx_if.disp_err = ($urandom_range(99) < ((m_state == 2) ? 3 : 1));
      rx_if.nit_err  = ($urandom_range(99) < ((m_state == 2) ? 2 : 1));
      lmfc_tick  = rx_if.vld && ($urandom_range(7) == 0);
      frame_tick = rx_if.vld && ($urandom_range(3) == 0);
      resync     = ($urandom_range(699) == 0);
      if ($urandom_range(199) == 0) err_rpt_en = ~err_rpt_en;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
